// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_mem_arbiter: round-robin I/D line-fill arbiter onto one memory read port
// Revision: 1.0
// ----------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_valid,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  i_grants,
  output logic [CNT_WIDTH-1:0]  d_grants
);

  localparam int                   WD_WIDTH = $clog2(TIMEOUT);
  localparam logic [WD_WIDTH-1:0]  WD_LAST  = WD_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic                 SIDE_I   = 1'b0;
  localparam logic                 SIDE_D   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [WD_WIDTH-1:0]   wdog_q, wdog_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_valid_q, i_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  i_grants_q, i_grants_d;
  logic [CNT_WIDTH-1:0]  d_grants_q, d_grants_d;

  logic                  grant_side;
  logic                  finish;
  logic [DATA_WIDTH-1:0] ret_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= SIDE_I;
      last_gnt_q <= SIDE_D;
      wdog_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      i_grants_q <= '0;
      d_grants_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wdog_q     <= wdog_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_valid_q  <= i_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
      i_grants_q <= i_grants_d;
      d_grants_q <= d_grants_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wdog_d     = wdog_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_valid_d  = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    i_grants_d = i_grants_q;
    d_grants_d = d_grants_q;
    grant_side = SIDE_I;
    finish     = 1'b0;
    ret_data   = '0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the side not served last wins; otherwise whoever asks.
        grant_side = (i_req && d_req) ? ~last_gnt_q : d_req;
        if (i_req || d_req) begin
          state_d    = ST_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = (grant_side == SIDE_D) ? d_addr : i_addr;
          gnt_d      = grant_side;
          wdog_d     = '0;
          if (grant_side == SIDE_D) begin
            if (d_grants_q != CNT_MAX) d_grants_d = d_grants_q + 1'b1;
          end else begin
            if (i_grants_q != CNT_MAX) i_grants_d = i_grants_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          finish   = 1'b1;
          ret_data = mem_rdata;
        end else if (wdog_q == WD_LAST) begin
          finish   = 1'b1;
          err_d    = 1'b1;
        end else begin
          wdog_d   = wdog_q + 1'b1;
        end
        if (finish) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          last_gnt_d = gnt_q;
          if (gnt_q == SIDE_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = ret_data;
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = ret_data;
          end
        end
      end
      // One dead cycle so the served requester can drop its request.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign i_valid  = i_valid_q;
  assign d_valid  = d_valid_q;
  assign err      = err_q;
  assign i_grants = i_grants_q;
  assign d_grants = d_grants_q;

endmodule
`default_nettype wire
